// File: rtl/sc_dac_mask_loader.sv
// Slow-control responder: latches DAC code + channel mask, shifts them MSB-first into the
// SKIROC chain, pulses load, then returns Finish-SC. Optional chain readback: SC_READBACK_EN.
module sc_dac_mask_loader #(
  parameter int unsigned DAC_W      = 12,
  parameter int unsigned MASK_W     = 64,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FINISH_LEN = 2
) (
  input  logic              Clk_10MHz,
  input  logic              Rst_N,
  input  logic              In_Set_SC,
  input  logic [DAC_W-1:0]  In_DAC_Code,
  input  logic [MASK_W-1:0] In_Mask_Code,
  input  logic              In_Sc_Srout,
  output logic              Out_Sc_Srin,
  output logic              Out_Sc_Clk,
  output logic              Out_Sc_Load,
  output logic              Out_Finish_Sc,
  output logic              Out_Busy,
  output logic              Out_Sc_Err
);

  localparam int unsigned N       = MASK_W + DAC_W;
  localparam int unsigned BIT_CYC = 2 * CLK_DIV;
  localparam int unsigned CNT_MAX = (BIT_CYC > FINISH_LEN) ? BIT_CYC : FINISH_LEN;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = $clog2(N + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
`ifdef SC_READBACK_EN
    S_VERIFY,
`endif
    S_LOAD,
    S_FINISH
  } state_t;

  state_t           state, state_n;
  logic             set_d;
  logic [CNT_W-1:0] div_cnt, div_n;
  logic [BIT_W-1:0] bit_cnt, bit_n;
  logic [N-1:0]     frame, frame_n;
  logic             shifting_n;
  logic             capture;
  logic             err_q, err_n;

  // Next-state, counters and next-cycle output values
  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    frame_n = frame;
    err_n   = err_q;
    capture = (state == S_IDLE) && In_Set_SC && !set_d;

    case (state)
      S_IDLE: begin
        if (capture) begin
          state_n = S_SHIFT;
          div_n   = '0;
          bit_n   = '0;
          frame_n = {In_Mask_Code, In_DAC_Code};
          err_n   = 1'b0;
        end
      end
`ifdef SC_READBACK_EN
      S_SHIFT, S_VERIFY: begin
        if (state == S_VERIFY && div_cnt == CNT_W'(CLK_DIV) && In_Sc_Srout != frame[N-1])
          err_n = 1'b1;
`else
      S_SHIFT: begin
`endif
        // Rotating the frame leaves it intact after N bits, ready for a second pass
        if (div_cnt == CNT_W'(BIT_CYC - 1)) begin
          div_n   = '0;
          frame_n = {frame[N-2:0], frame[N-1]};
          if (bit_cnt == BIT_W'(N - 1)) begin
            bit_n = '0;
`ifdef SC_READBACK_EN
            state_n = (state == S_SHIFT) ? S_VERIFY : S_LOAD;
`else
            state_n = S_LOAD;
`endif
          end else begin
            bit_n = bit_cnt + BIT_W'(1);
          end
        end else begin
          div_n = div_cnt + CNT_W'(1);
        end
      end
      S_LOAD: begin
        if (div_cnt == CNT_W'(CLK_DIV - 1)) begin
          state_n = S_FINISH;
          div_n   = '0;
        end else begin
          div_n = div_cnt + CNT_W'(1);
        end
      end
      S_FINISH: begin
        if (div_cnt == CNT_W'(FINISH_LEN - 1)) begin
          state_n = S_IDLE;
          div_n   = '0;
        end else begin
          div_n = div_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        div_n   = '0;
        bit_n   = '0;
      end
    endcase

`ifdef SC_READBACK_EN
    shifting_n = (state_n == S_SHIFT) || (state_n == S_VERIFY);
`else
    shifting_n = (state_n == S_SHIFT);
`endif
  end

  // State, counters and registered outputs
  always_ff @(posedge Clk_10MHz) begin
    if (!Rst_N) begin
      state         <= S_IDLE;
      set_d         <= 1'b0;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      frame         <= '0;
      err_q         <= 1'b0;
      Out_Sc_Srin   <= 1'b0;
      Out_Sc_Clk    <= 1'b0;
      Out_Sc_Load   <= 1'b0;
      Out_Finish_Sc <= 1'b0;
      Out_Busy      <= 1'b0;
    end else begin
      state         <= state_n;
      set_d         <= In_Set_SC;
      div_cnt       <= div_n;
      bit_cnt       <= bit_n;
      frame         <= frame_n;
      err_q         <= err_n;
      Out_Sc_Srin   <= shifting_n && frame_n[N-1];
      Out_Sc_Clk    <= shifting_n && (div_n >= CNT_W'(CLK_DIV));
      Out_Sc_Load   <= (state_n == S_LOAD);
      Out_Finish_Sc <= (state_n == S_FINISH);
      Out_Busy      <= (state_n != S_IDLE);
    end
  end

`ifdef SC_READBACK_EN
  assign Out_Sc_Err = err_q;
`else
  logic unused_srout;
  assign unused_srout = In_Sc_Srout ^ err_q ^ err_n;
  assign Out_Sc_Err   = 1'b0;
`endif

endmodule
